// File: rtl/mod_prefix_adder_pipe.sv
// Pipelined parallel-prefix adder, run-time modulus 2^WIDTH-1 (end-around carry) or 2^WIDTH.
// Latency LEVELS+2 register stages; a single global enable stalls every stage when the output is held.
module mod_prefix_adder_pipe #(
  parameter int WIDTH     = 16,
  parameter bit NORM_ZERO = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int LEVELS = $clog2(WIDTH);

  logic             en;
  logic [WIDTH-1:0] g_q [0:LEVELS];
  logic [WIDTH-1:0] x_q [0:LEVELS];
  logic [WIDTH-1:0] p_q [0:LEVELS-1];
  logic [LEVELS:0]  m_q;
  logic [LEVELS:0]  v_q;
  logic [WIDTH-1:0] g_d [1:LEVELS];
  logic [WIDTH-1:0] p_d [1:LEVELS-1];
  logic [WIDTH-1:0] carry;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] res;

  assign en       = out_ready | ~out_valid;
  assign in_ready = en;

  // Operand at cyclic index i-d; wrapped positions read as 0 in plain (mode 1) arithmetic.
  function automatic logic tap(input logic [WIDTH-1:0] v, input int i, input int d, input logic m);
    return (m && (i < d)) ? 1'b0 : v[(i - d) & (WIDTH - 1)];
  endfunction

  always_comb begin
    for (int k = 1; k <= LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        g_d[k][i] = g_q[k-1][i] | (p_q[k-1][i] & tap(g_q[k-1], i, 1 << (k - 1), m_q[k-1]));
      end
    end
    // The last level's propagate is never consumed, so it is not built.
    for (int k = 1; k < LEVELS; k++) begin
      for (int i = 0; i < WIDTH; i++) begin
        p_d[k][i] = p_q[k-1][i] & tap(p_q[k-1], i, 1 << (k - 1), m_q[k-1]);
      end
    end
  end

  always_comb begin
    carry = {g_q[LEVELS][WIDTH-2:0], ~m_q[LEVELS] & g_q[LEVELS][WIDTH-1]};
    raw   = x_q[LEVELS] ^ carry;
    res   = (NORM_ZERO && !m_q[LEVELS] && (&raw)) ? '0 : raw;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k <= LEVELS; k++) begin
        g_q[k] <= '0;
        x_q[k] <= '0;
      end
      for (int k = 0; k < LEVELS; k++) p_q[k] <= '0;
      m_q       <= '0;
      v_q       <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
    end else if (en) begin
      v_q    <= {v_q[LEVELS-1:0], in_valid};
      m_q    <= {m_q[LEVELS-1:0], mode};
      g_q[0] <= a & b;
      p_q[0] <= a | b;
      x_q[0] <= a ^ b;
      for (int k = 1; k <= LEVELS; k++) begin
        g_q[k] <= g_d[k];
        x_q[k] <= x_q[k-1];
      end
      for (int k = 1; k < LEVELS; k++) p_q[k] <= p_d[k];
      out_valid <= v_q[LEVELS];
      sum       <= res;
      cout      <= g_q[LEVELS][WIDTH-1];
    end
  end
endmodule

// File: tb/tb_mod_prefix_adder_pipe.sv
// Directed bench for mod_prefix_adder_pipe at widths 4, 8 (both zero encodings), 16 and 64.
module tb_mod_prefix_adder_pipe;
  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready, mode;
  logic [63:0] a, b;

  logic r4, v4, c4, r8a, v8a, c8a, r8b, v8b, c8b, r16, v16, c16, r64, v64, c64;
  logic [3:0]  s4;
  logic [7:0]  s8a, s8b;
  logic [15:0] s16;
  logic [63:0] s64;

  int n_checks = 0;
  int n_fail   = 0;

  int lat4, lat8a, lat8b, lat16, lat64;
  logic [3:0]  cs4;
  logic [7:0]  cs8a, cs8b;
  logic [15:0] cs16;
  logic [63:0] cs64;
  logic cc4, cc8a, cc8b, cc16, cc64;

  always #5 clk = ~clk;

  mod_prefix_adder_pipe #(.WIDTH(4), .NORM_ZERO(1'b1)) u4 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r4),
    .a(a[3:0]), .b(b[3:0]), .mode(mode), .out_valid(v4), .out_ready(out_ready), .sum(s4), .cout(c4));
  mod_prefix_adder_pipe #(.WIDTH(8), .NORM_ZERO(1'b1)) u8a (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8a),
    .a(a[7:0]), .b(b[7:0]), .mode(mode), .out_valid(v8a), .out_ready(out_ready), .sum(s8a), .cout(c8a));
  mod_prefix_adder_pipe #(.WIDTH(8), .NORM_ZERO(1'b0)) u8b (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r8b),
    .a(a[7:0]), .b(b[7:0]), .mode(mode), .out_valid(v8b), .out_ready(out_ready), .sum(s8b), .cout(c8b));
  mod_prefix_adder_pipe #(.WIDTH(16), .NORM_ZERO(1'b1)) u16 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r16),
    .a(a[15:0]), .b(b[15:0]), .mode(mode), .out_valid(v16), .out_ready(out_ready), .sum(s16), .cout(c16));
  mod_prefix_adder_pipe #(.WIDTH(64), .NORM_ZERO(1'b1)) u64 (.clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r64),
    .a(a), .b(b), .mode(mode), .out_valid(v64), .out_ready(out_ready), .sum(s64), .cout(c64));

  // Golden 16-bit result {cout, sum}; mode 0 folds the carry back and maps the redundant zero to 0.
  function automatic logic [16:0] m16(input logic [15:0] x, input logic [15:0] y, input logic m);
    logic [16:0] s;
    logic [15:0] r;
    s = {1'b0, x} + {1'b0, y};
    r = s[15:0] + {15'd0, s[16]};
    if (&r) r = '0;
    return m ? s : {s[16], r};
  endfunction

  // One beat into every instance; records edges-to-output (accept edge = 1) and the result.
  task automatic run_single(input logic [63:0] ai, input logic [63:0] bi, input logic m);
    a = ai; b = bi; mode = m; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat4 = 0; lat8a = 0; lat8b = 0; lat16 = 0; lat64 = 0;
    for (int e = 1; e <= 12; e++) begin
      if (lat4 == 0 && v4)   begin lat4 = e;  cs4 = s4;   cc4 = c4;   end
      if (lat8a == 0 && v8a) begin lat8a = e; cs8a = s8a; cc8a = c8a; end
      if (lat8b == 0 && v8b) begin lat8b = e; cs8b = s8b; cc8b = c8b; end
      if (lat16 == 0 && v16) begin lat16 = e; cs16 = s16; cc16 = c16; end
      if (lat64 == 0 && v64) begin lat64 = e; cs64 = s64; cc64 = c64; end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; mode = 1'b0; a = '0; b = '0;
    #12;
    n_checks++; if (v16 !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got %b want 0", v16); end
    n_checks++; if (s16 !== 16'h0 || c16 !== 1'b0) begin n_fail++; $display("FAIL reset_sum_cout got %h/%b want 0/0", s16, c16); end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (r16 !== 1'b1 || r8a !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got %b%b want 11", r16, r8a); end
    n_checks++; if (v8a !== 1'b0 || s8a !== 8'h0) begin n_fail++; $display("FAIL reset_w8 got %b/%h want 0/00", v8a, s8a); end
  endtask

  task automatic test_mod8_basic;
    run_single(64'h0F, 64'hF1, 1'b0);
    n_checks++; if (lat8a !== 5) begin n_fail++; $display("FAIL lat_w8 got %0d want 5", lat8a); end
    n_checks++; if (lat16 !== 6) begin n_fail++; $display("FAIL lat_w16 got %0d want 6", lat16); end
    n_checks++; if (cs8a !== 8'h01 || cc8a !== 1'b1) begin n_fail++; $display("FAIL w8_m0 got %h/%b want 01/1", cs8a, cc8a); end
    n_checks++; if (cs16 !== 16'h0100 || cc16 !== 1'b0) begin n_fail++; $display("FAIL w16_m0 got %h/%b want 0100/0", cs16, cc16); end
    run_single(64'h0F, 64'hF1, 1'b1);
    n_checks++; if (cs8a !== 8'h00 || cc8a !== 1'b1) begin n_fail++; $display("FAIL w8_m1 got %h/%b want 00/1", cs8a, cc8a); end
    n_checks++; if (lat8a !== 5) begin n_fail++; $display("FAIL lat_w8_m1 got %0d want 5", lat8a); end
  endtask

  task automatic test_redundant_zero;
    run_single(64'h00, 64'hFF, 1'b0);
    n_checks++; if (cs8a !== 8'h00 || cc8a !== 1'b0) begin n_fail++; $display("FAIL rz_norm_0_ff got %h/%b want 00/0", cs8a, cc8a); end
    n_checks++; if (cs8b !== 8'hFF || cc8b !== 1'b0) begin n_fail++; $display("FAIL rz_raw_0_ff got %h/%b want ff/0", cs8b, cc8b); end
    run_single(64'hFF, 64'hFF, 1'b0);
    n_checks++; if (cs8a !== 8'h00 || cc8a !== 1'b1) begin n_fail++; $display("FAIL rz_norm_ff_ff got %h/%b want 00/1", cs8a, cc8a); end
    n_checks++; if (cs8b !== 8'hFF || cc8b !== 1'b1) begin n_fail++; $display("FAIL rz_raw_ff_ff got %h/%b want ff/1", cs8b, cc8b); end
  endtask

  task automatic test_corners;
    run_single({64{1'b1}}, 64'h1, 1'b1);
    n_checks++; if (cs4 !== 4'h0 || cc4 !== 1'b1) begin n_fail++; $display("FAIL w4_m1 got %h/%b want 0/1", cs4, cc4); end
    n_checks++; if (cs64 !== 64'h0 || cc64 !== 1'b1) begin n_fail++; $display("FAIL w64_m1 got %h/%b want 0/1", cs64, cc64); end
    n_checks++; if (lat4 !== 4 || lat64 !== 8) begin n_fail++; $display("FAIL lat_w4_w64 got %0d/%0d want 4/8", lat4, lat64); end
    run_single({64{1'b1}}, 64'h1, 1'b0);
    n_checks++; if (cs4 !== 4'h1 || cc4 !== 1'b1) begin n_fail++; $display("FAIL w4_m0 got %h/%b want 1/1", cs4, cc4); end
    n_checks++; if (cs64 !== 64'h1 || cc64 !== 1'b1) begin n_fail++; $display("FAIL w64_m0 got %h/%b want 1/1", cs64, cc64); end
  endtask

  // Random stream through the 16-bit instance; stall_at >= 0 holds out_ready low for 3 cycles
  // once that many results have been taken.
  task automatic test_stream(input int n, input int stall_at);
    logic [16:0] q[$];
    logic [16:0] exp;
    logic [15:0] ra, rb;
    logic rm;
    int sent = 0, got = 0, cyc = 0, stall_left = 0, first = -1, last = -1, extra = 0;
    bit stalled = 0, have = 0;
    ra = '0; rb = '0; rm = 1'b0;
    out_ready = 1'b1; in_valid = 1'b0;
    while (got < n && cyc < 4 * n + 60) begin
      if (v16 && stall_at >= 0 && !stalled && got == stall_at) begin stalled = 1; stall_left = 3; end
      if (stall_left > 0) begin
        out_ready = 1'b0;
        n_checks++;
        if (v16 !== 1'b1 || q.size() == 0 || {c16, s16} !== q[0]) begin
          n_fail++; $display("FAIL stall_hold got %b/%h", v16, {c16, s16});
        end
        stall_left--;
      end else out_ready = 1'b1;
      if (v16 && out_ready) begin
        if (first < 0) first = cyc;
        last = cyc;
        n_checks++;
        if (q.size() == 0) begin n_fail++; $display("FAIL stream_extra got %h want none", {c16, s16}); end
        else begin
          exp = q.pop_front();
          if ({c16, s16} !== exp) begin n_fail++; $display("FAIL stream_beat%0d got %h want %h", got, {c16, s16}, exp); end
        end
        got++;
      end
      if (!have && sent < n) begin
        ra = 16'($urandom); rb = 16'($urandom); rm = 1'($urandom_range(0, 1)); have = 1;
      end
      a = {48'd0, ra}; b = {48'd0, rb}; mode = rm; in_valid = have;
      #1;
      if (!out_ready) begin
        n_checks++; if (r16 !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready got %b want 0", r16); end
      end
      if (have && r16) begin q.push_back(m16(ra, rb, rm)); sent++; have = 0; end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n_checks++; if (got != n) begin n_fail++; $display("FAIL stream_count got %0d want %0d", got, n); end
    if (stall_at < 0) begin
      n_checks++;
      if (first != 6 || last - first != n - 1) begin
        n_fail++; $display("FAIL stream_rate got first=%0d span=%0d want 6/%0d", first, last - first, n - 1);
      end
    end
    repeat (8) begin if (v16) extra++; @(posedge clk); #1; end
    n_checks++; if (extra != 0 || q.size() != 0) begin n_fail++; $display("FAIL stream_leftover got %0d/%0d want 0/0", extra, q.size()); end
  endtask

  task automatic test_reset_midstream;
    bit ghost = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      a = 64'(i + 1); b = 64'hFFFF; mode = 1'b1; in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (v16 !== 1'b1 || s16 !== 16'h1 || c16 !== 1'b1) begin n_fail++; $display("FAIL pre_reset_beat got %b/%h/%b want 1/0001/1", v16, s16, c16); end
    rst = 1'b1;
    #1;
    n_checks++; if (v16 !== 1'b0 || s16 !== 16'h0 || c16 !== 1'b0) begin n_fail++; $display("FAIL async_reset got %b/%h/%b want 0/0000/0", v16, s16, c16); end
    @(posedge clk); #4;
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (r16 !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got %b want 1", r16); end
    repeat (12) begin if (v16) ghost = 1; @(posedge clk); #1; end
    n_checks++; if (ghost !== 1'b0) begin n_fail++; $display("FAIL ghost_beat got 1 want 0"); end
    run_single(64'h1234, 64'h4321, 1'b1);
    n_checks++; if (lat16 !== 6) begin n_fail++; $display("FAIL post_reset_lat got %0d want 6", lat16); end
    n_checks++; if (cs16 !== 16'h5555 || cc16 !== 1'b0) begin n_fail++; $display("FAIL post_reset_beat got %h/%b want 5555/0", cs16, cc16); end
  endtask

  initial begin
    test_reset;
    test_mod8_basic;
    test_redundant_zero;
    test_corners;
    test_stream(1000, -1);
    test_stream(16, 4);
    test_reset_midstream;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
